// File: rtl/srt_quotient_converter.sv
// On-the-fly conversion of signed-digit SRT quotient digits (MSB first) into a
// binary quotient, with final Q / Q-1 selection driven by the remainder sign.
module srt_quotient_converter #(
    parameter int unsigned PARALLELISM = 32,
    parameter int unsigned CNT_W       = $clog2(PARALLELISM + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   flush,
    input  logic                   digit_valid,
    input  logic                   sign_sel,
    input  logic                   non0,
    input  logic                   corr_valid,
    input  logic                   corr_use_qm,
    output logic                   busy,
    output logic                   q_valid,
    input  logic                   q_ready,
    output logic [PARALLELISM-1:0] quotient
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] CONVERT   = 2'd1;
    localparam logic [1:0] WAIT_CORR = 2'd2;
    localparam logic [1:0] OUTPUT    = 2'd3;

    logic [1:0]             state;
    logic [1:0]             stateNext;
    logic [PARALLELISM-1:0] qReg;
    logic [PARALLELISM-1:0] qmReg;
    logic [PARALLELISM-1:0] qNext;
    logic [PARALLELISM-1:0] qmNext;
    logic [PARALLELISM-1:0] quotNext;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cntNext;

    // Next-state and datapath update; QM always tracks Q-1 so no final adder is needed
    always_comb begin
        stateNext = state;
        qNext     = qReg;
        qmNext    = qmReg;
        quotNext  = quotient;
        cntNext   = cnt;

        if (flush) begin
            stateNext = IDLE;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        qNext     = '0;
                        qmNext    = '1;
                        cntNext   = '0;
                        stateNext = CONVERT;
                    end
                end
                CONVERT: begin
                    if (digit_valid) begin
                        if (!non0) begin
                            qNext  = {qReg[PARALLELISM-2:0], 1'b0};
                            qmNext = {qmReg[PARALLELISM-2:0], 1'b1};
                        end else if (!sign_sel) begin
                            qNext  = {qReg[PARALLELISM-2:0], 1'b1};
                            qmNext = {qReg[PARALLELISM-2:0], 1'b0};
                        end else begin
                            qNext  = {qmReg[PARALLELISM-2:0], 1'b1};
                            qmNext = {qmReg[PARALLELISM-2:0], 1'b0};
                        end
                        cntNext = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(PARALLELISM - 1)) begin
                            stateNext = WAIT_CORR;
                        end
                    end
                end
                WAIT_CORR: begin
                    if (corr_valid) begin
                        quotNext  = corr_use_qm ? qmReg : qReg;
                        stateNext = OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (q_ready) begin
                        stateNext = IDLE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            qReg     <= '0;
            qmReg    <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            q_valid  <= 1'b0;
        end else begin
            state    <= stateNext;
            qReg     <= qNext;
            qmReg    <= qmNext;
            quotient <= quotNext;
            cnt      <= cntNext;
            busy     <= (stateNext != IDLE);
            q_valid  <= (stateNext == OUTPUT);
        end
    end

endmodule

// File: tb/tb_srt_quotient_converter.sv
// Bench for srt_quotient_converter: directed vector table, corner sequences and
// randomized conversions checked against an integer-arithmetic reference.
module tb_srt_quotient_converter;

    localparam int unsigned P  = 4;
    localparam int unsigned CW = $clog2(P + 1);

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic         digit_valid;
    logic         sign_sel;
    logic         non0;
    logic         corr_valid;
    logic         corr_use_qm;
    logic         busy;
    logic         q_valid;
    logic         q_ready;
    logic [P-1:0] quotient;

    int checks = 0;
    int errors = 0;

    srt_quotient_converter #(.PARALLELISM(P), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .digit_valid(digit_valid), .sign_sel(sign_sel), .non0(non0),
        .corr_valid(corr_valid), .corr_use_qm(corr_use_qm),
        .busy(busy), .q_valid(q_valid), .q_ready(q_ready), .quotient(quotient)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A digit must never be offered in CONVERT once all digits were taken
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(digit_valid && dut.state == dut.CONVERT && dut.cnt == CW'(P)))
                else $error("digit_valid in CONVERT with full digit count");
        end
    end

    typedef struct {
        logic [P-1:0] nz;
        logic [P-1:0] sg;
        logic         corr;
        logic [P-1:0] expQ;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: quotient value is the plain sum of d_i * 2^i, minus one if corrected
    function automatic logic [P-1:0] refQuot(input logic [P-1:0] nz, input logic [P-1:0] sg,
                                              input logic corr);
        int v = 0;
        for (int i = P - 1; i >= 0; i--) begin
            v = v * 2 + (nz[i] ? (sg[i] ? -1 : 1) : 0);
        end
        if (corr) v = v - 1;
        return P'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startConv();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic sendDigit(input logic nz, input logic sg);
        digit_valid = 1'b1;
        non0        = nz;
        sign_sel    = sg;
        tick();
        digit_valid = 1'b0;
        non0        = 1'b0;
        sign_sel    = 1'b0;
    endtask

    task automatic sendCorr(input logic c, input logic [P-1:0] expQ, input string name);
        check({name, "_pre_qvalid"}, 32'(q_valid), 32'd0);
        corr_valid  = 1'b1;
        corr_use_qm = c;
        tick();
        corr_valid  = 1'b0;
        corr_use_qm = 1'b0;
        check({name, "_qvalid"}, 32'(q_valid), 32'd1);
        check({name, "_quot"}, 32'(quotient), 32'(expQ));
    endtask

    task automatic handshake(input string name);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check({name, "_hs_qvalid"}, 32'(q_valid), 32'd0);
        check({name, "_hs_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [P-1:0] nz;
        logic [P-1:0] sg;
        logic         c;
        logic [P-1:0] expQ;
        int           gaps;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; digit_valid = 1'b0;
        sign_sel = 1'b0; non0 = 1'b0; corr_valid = 1'b0; corr_use_qm = 1'b0;
        q_ready = 1'b0;

        vecs[0] = '{nz: 4'b1011, sg: 4'b0010, corr: 1'b0, expQ: 4'h7};
        vecs[1] = '{nz: 4'b1011, sg: 4'b0010, corr: 1'b1, expQ: 4'h6};
        vecs[2] = '{nz: 4'b1111, sg: 4'b1111, corr: 1'b0, expQ: 4'h1};
        vecs[3] = '{nz: 4'b0000, sg: 4'b0101, corr: 1'b0, expQ: 4'h0};
        vecs[4] = '{nz: 4'b0000, sg: 4'b1111, corr: 1'b1, expQ: 4'hF};
        vecs[5] = '{nz: 4'b1111, sg: 4'b0000, corr: 1'b0, expQ: 4'hF};
        vecs[6] = '{nz: 4'b1111, sg: 4'b0101, corr: 1'b1, expQ: 4'h4};
        vecs[7] = '{nz: 4'b1100, sg: 4'b1000, corr: 1'b0, expQ: 4'hC};

        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_qvalid", 32'(q_valid), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed table, digits back to back
        for (int v = 0; v < 8; v++) begin
            startConv();
            for (int i = P - 1; i >= 0; i--) sendDigit(vecs[v].nz[i], vecs[v].sg[i]);
            check("vec_busy_wait", 32'(busy), 32'd1);
            sendCorr(vecs[v].corr, vecs[v].expQ, $sformatf("vec%0d", v));
            handshake($sformatf("vec%0d", v));
        end

        // Gapped delivery 1,0,0,1,1,0,1 then a stray digit in WAIT_CORR
        begin
            int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
            int k = P - 1;
            startConv();
            for (int i = 0; i < 7; i++) begin
                if (pat[i] == 1) begin
                    sendDigit(vecs[0].nz[k], vecs[0].sg[k]);
                    k--;
                end else begin
                    tick();
                end
                check("gap_busy", 32'(busy), 32'd1);
            end
            sendDigit(1'b1, 1'b1);
            check("gap_stray_busy", 32'(busy), 32'd1);
            sendCorr(1'b0, 4'h7, "gap");
            handshake("gap");
        end

        // Output stall with q_ready low, start pulsed meanwhile and at handshake
        startConv();
        for (int i = 0; i < 4; i++) sendDigit(1'b1, 1'b0);
        sendCorr(1'b0, 4'hF, "stall");
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("stall_qvalid", 32'(q_valid), 32'd1);
            check("stall_quot", 32'(quotient), 32'hF);
        end
        start = 1'b1;
        handshake("stall");
        start = 1'b0;
        tick();
        check("stall_idle_busy", 32'(busy), 32'd0);

        // Flush in WAIT_CORR: back to IDLE, later corr_valid ignored, quotient kept
        startConv();
        sendDigit(1'b1, 1'b1); sendDigit(1'b1, 1'b0); sendDigit(1'b0, 1'b0); sendDigit(1'b0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_qvalid", 32'(q_valid), 32'd0);
        check("flush_quot", 32'(quotient), 32'hF);
        corr_valid = 1'b1;
        tick();
        corr_valid = 1'b0;
        check("flush_corr_qvalid", 32'(q_valid), 32'd0);
        check("flush_corr_quot", 32'(quotient), 32'hF);
        startConv();
        for (int i = P - 1; i >= 0; i--) sendDigit(vecs[0].nz[i], vecs[0].sg[i]);
        sendCorr(1'b0, 4'h7, "post_flush");
        handshake("post_flush");

        // Asynchronous reset after two digits
        startConv();
        sendDigit(1'b1, 1'b0);
        sendDigit(1'b0, 1'b0);
        check("prereset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_qvalid", 32'(q_valid), 32'd0);
        check("areset_quot", 32'(quotient), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postreset_busy", 32'(busy), 32'd0);

        // Randomized conversions against the arithmetic reference
        for (int n = 0; n < 60; n++) begin
            nz   = P'($urandom);
            sg   = P'($urandom);
            c    = 1'($urandom);
            expQ = refQuot(nz, sg, c);
            startConv();
            for (int i = P - 1; i >= 0; i--) begin
                gaps = int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++) tick();
                sendDigit(nz[i], sg[i]);
            end
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) tick();
            sendCorr(c, expQ, "rand");
            gaps = int'($urandom_range(0, 3));
            for (int g = 0; g < gaps; g++) begin
                tick();
                check("rand_hold_qvalid", 32'(q_valid), 32'd1);
                check("rand_hold_quot", 32'(quotient), 32'(expQ));
            end
            handshake("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srt_quotient_converter.md
Name: srt_quotient_converter

Overview:
- Consumes the per-iteration quotient digits that the division kernel emits as its SignSel/Non0 pair.
- Assembles them into a conventional binary quotient using on-the-fly conversion, so no carry-propagate adder is needed at the end.
- Applies the datapath's final remainder-sign correction by choosing Q or Q-1, then presents the result on a valid/ready output.
- Sits beside the kernel inside the multiply/division unit and is controlled by the unit FSM.

Parameters:
- PARALLELISM, 32, quotient width in bits; also the number of digits per division.
- CNT_W, $clog2(PARALLELISM+1), width of the digit counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new conversion; accepted only in IDLE.
- flush  input  1  synchronous abort to IDLE from any state.
- digit_valid  input  1  sign_sel/non0 carry one digit this cycle.
- sign_sel  input  1  digit sign, same encoding as the kernel's SignSel.
- non0  input  1  digit non-zero, same encoding as the kernel's Non0.
- corr_valid  input  1  final correction decision is present.
- corr_use_qm  input  1  1 = final remainder needed correction, so output Q-1.
- busy  output  1  high in any state other than IDLE.
- q_valid  output  1  quotient available.
- q_ready  input  1  consumer accepts the quotient.
- quotient  output  PARALLELISM  converted quotient, two's complement, modulo 2^PARALLELISM.

Behaviour:
- Digit decode:
  - non0=0 gives digit 0, whatever sign_sel is.
  - {non0,sign_sel}=10 gives +1.
  - {non0,sign_sel}=11 gives -1.
- Registers: Q and QM, both PARALLELISM bits. Invariant: QM = Q-1 mod 2^PARALLELISM. Digits arrive MSB first.
- Update on each accepted digit (left shift, MSB dropped):
  - +1: Q<={Q,1}, QM<={Q,0}.
  - 0: Q<={Q,0}, QM<={QM,1}.
  - -1: Q<={QM,1}, QM<={QM,0}.
- States: IDLE, CONVERT, WAIT_CORR, OUTPUT.
- IDLE:
  - start=1 loads Q<=0, QM<=all ones and cnt<=0, then moves to CONVERT next cycle.
  - digit_valid and corr_valid are ignored.
- CONVERT:
  - Each cycle with digit_valid=1 applies the update and increments cnt.
  - The cycle that accepts digit number PARALLELISM moves to WAIT_CORR.
  - Cycles with digit_valid=0 hold all state.
  - start is ignored.
- WAIT_CORR:
  - Digits are ignored.
  - corr_valid=1 latches quotient<=corr_use_qm ? QM : Q and moves to OUTPUT. q_valid is high the next cycle.
- OUTPUT:
  - q_valid=1 and quotient are held stable until q_valid&&q_ready.
  - On that handshake cycle the block returns to IDLE; q_valid is low the next cycle.
  - start in the handshake cycle is ignored. A new start is accepted only once IDLE is reached.
- Latencies:
  - start to first digit accepted: 1 cycle minimum.
  - Last digit to corr_valid accepted: 1 cycle minimum.
  - corr_valid to q_valid: 1 cycle.
- flush:
  - Has priority over all other inputs.
  - Next cycle: IDLE, q_valid=0, cnt=0. Q, QM and quotient are unchanged.
- Reset (rst_n=0, asynchronous, also mid-operation):
  - State IDLE; Q, QM, quotient, cnt = 0.
  - q_valid=0, busy=0.
- Overflow and sign are not interpreted: the result wraps modulo 2^PARALLELISM. Signed/unsigned interpretation belongs to the unit.
- Assertion (bench): digit_valid must never be seen in CONVERT when cnt==PARALLELISM.

Test Plan:
- PARALLELISM=4; start; digits +1,0,-1,+1 on consecutive cycles; corr_use_qm=0 -> Q=0111, QM=0110; quotient=4'd7, q_valid 1 cycle after corr_valid.
- Same digits with corr_use_qm=1 -> quotient=4'd6.
- PARALLELISM=4; digits -1,-1,-1,-1 -> Q=0001 (−15 mod 16); all-zero digits -> Q=0000, QM=1111; with corr_use_qm=1 -> quotient=4'hF.
- digit_valid gapped (1,0,0,1,1,0,1) -> same result as back-to-back delivery. The 5th digit_valid pulse in WAIT_CORR is ignored and Q is unchanged. busy stays high throughout.
- q_ready held low 5 cycles in OUTPUT -> q_valid and quotient stable all 5 cycles; start pulsed meanwhile is ignored; IDLE follows the handshake.
- rst_n asserted after 2 digits -> outputs zero immediately. flush in WAIT_CORR -> IDLE next cycle, and a following corr_valid produces no q_valid.
